// File: rtl/au_seq.sv
// Operand/sequencing stage feeding the arithmetic unit: holds RA/RB, issues
// one-cycle ALU requests, writes results back, and presents OUT results downstream.
module au_seq #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_data,
  output logic              au_en,
  output logic [3:0]        ac,
  output logic [DATA_W-1:0] au_a,
  output logic [DATA_W-1:0] au_b,
  input  logic [DATA_W-1:0] au_t,
  input  logic              au_gf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              gf_q,
  output logic [DATA_W-1:0] ra_q,
  output logic [DATA_W-1:0] rb_q,
  output logic              bad_op
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_EXEC     = 2'd1;
  localparam logic [1:0] S_OUT_WAIT = 2'd2;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDA  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1001;
  localparam logic [3:0] OP_MOVA = 4'b0100;
  localparam logic [3:0] OP_MOVB = 4'b0101;
  localparam logic [3:0] OP_OUT  = 4'b1101;

  logic [1:0]        r_state;
  logic [3:0]        r_ac;
  logic [DATA_W-1:0] r_ra;
  logic [DATA_W-1:0] r_rb;
  logic              r_gf;
  logic [DATA_W-1:0] r_out_data;
  logic              r_bad_op;

  logic w_accept;
  logic w_exec;

  assign in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_exec   = (r_state == S_EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ac       <= 4'b0000;
      r_ra       <= '0;
      r_rb       <= '0;
      r_gf       <= 1'b0;
      r_out_data <= '0;
      r_bad_op   <= 1'b0;
    end else begin
      r_bad_op <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (in_op)
              OP_NOP: ;
              OP_LDA: r_ra <= in_data;
              OP_LDB: r_rb <= in_data;
              OP_ADD, OP_SUB, OP_MOVA, OP_MOVB, OP_OUT: begin
                r_ac    <= in_op;
                r_state <= S_EXEC;
              end
              default: r_bad_op <= 1'b1;
            endcase
          end
        end
        S_EXEC: begin
          // au_t is only valid here; the unit floats it while disabled.
          case (r_ac)
            OP_ADD: begin
              r_ra <= au_t;
              r_gf <= 1'b0;
            end
            OP_SUB: begin
              r_ra <= au_t;
              r_gf <= au_gf;
            end
            OP_MOVA: r_ra <= au_t;
            OP_MOVB: r_rb <= au_t;
            OP_OUT:  r_out_data <= au_t;
            default: ;
          endcase
          r_state <= (r_ac == OP_OUT) ? S_OUT_WAIT : S_IDLE;
        end
        S_OUT_WAIT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign au_en = w_exec;
  assign ac    = w_exec ? r_ac : 4'b0000;
  assign au_a  = !w_exec ? '0 : ((r_ac == OP_MOVA) ? r_rb : r_ra);
  assign au_b  = (w_exec && ((r_ac == OP_ADD) || (r_ac == OP_SUB))) ? r_rb : '0;

  assign out_valid = (r_state == S_OUT_WAIT);
  assign out_data  = r_out_data;
  assign gf_q      = r_gf;
  assign ra_q      = r_ra;
  assign rb_q      = r_rb;
  assign bad_op    = r_bad_op;

endmodule

// File: tb/tb_au_seq.sv
// Directed bench for au_seq with a behavioural arithmetic unit attached.
module tb_au_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_data;
  logic       au_en;
  logic [3:0] ac;
  logic [7:0] au_a;
  logic [7:0] au_b;
  logic [7:0] au_t;
  logic       au_gf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       gf_q;
  logic [7:0] ra_q;
  logic [7:0] rb_q;
  logic       bad_op;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  au_seq #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_data(in_data),
    .au_en(au_en), .ac(ac), .au_a(au_a), .au_b(au_b), .au_t(au_t), .au_gf(au_gf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .gf_q(gf_q), .ra_q(ra_q), .rb_q(rb_q), .bad_op(bad_op)
  );

  // Arithmetic unit model; drives junk while disabled so stray sampling shows up.
  always_comb begin
    au_t  = 8'hA5;
    au_gf = 1'b1;
    if (au_en) begin
      au_gf = ($signed(au_b) > $signed(au_a));
      case (ac)
        4'b1000: au_t = au_a + au_b;
        4'b1001: au_t = au_b - au_a;
        default: au_t = au_a;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction, wait (bounded) for acceptance, leave 1ns past the edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] d);
    bit done = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk); done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    $display("issue op=%b data=%02h accepted=%0d", op, d, done);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_data = 8'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ra", ra_q, 0);
    chk("rst_rb", rb_q, 0);
    chk("rst_gf", gf_q, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_au_en", au_en, 0);
    chk("rst_ac", ac, 0);
    chk("rst_bad_op", bad_op, 0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", in_ready, 1);

    // ADD with wrap
    issue(4'b0001, 8'd100);
    issue(4'b0010, 8'd100);
    issue(4'b1000, 8'd0);
    chk("add_au_en", au_en, 1);
    chk("add_ac", ac, 4'b1000);
    chk("add_au_a", au_a, 8'd100);
    chk("add_au_b", au_b, 8'd100);
    chk("add_exec_in_ready", in_ready, 0);
    tick();
    chk("add_ra", ra_q, 8'hC8);
    chk("add_gf", gf_q, 0);
    chk("add_post_au_en", au_en, 0);
    chk("add_post_ac", ac, 0);
    chk("add_post_in_ready", in_ready, 1);

    // ADD where the unit reports greater: flag must still clear
    issue(4'b0001, 8'd1);
    issue(4'b0010, 8'd5);
    issue(4'b1000, 8'd0);
    tick();
    chk("add2_ra", ra_q, 8'd6);
    chk("add2_gf", gf_q, 0);

    // SUB both directions
    issue(4'b0001, 8'd3);
    issue(4'b0010, 8'd10);
    issue(4'b1001, 8'd0);
    chk("sub_ac", ac, 4'b1001);
    tick();
    chk("sub1_ra", ra_q, 8'd7);
    chk("sub1_gf", gf_q, 1);
    issue(4'b0001, 8'd10);
    issue(4'b0010, 8'd3);
    issue(4'b1001, 8'd0);
    tick();
    chk("sub2_ra", ra_q, 8'hF9);
    chk("sub2_gf", gf_q, 0);
    issue(4'b0001, 8'd3);
    issue(4'b0010, 8'd10);
    issue(4'b1001, 8'd0);
    tick();
    chk("sub3_gf", gf_q, 1);

    // MOVB / MOVA keep gf_q
    issue(4'b0001, 8'h55);
    issue(4'b0010, 8'h22);
    issue(4'b0101, 8'd0);
    chk("movb_au_a", au_a, 8'h55);
    chk("movb_au_b", au_b, 8'h00);
    tick();
    chk("movb_rb", rb_q, 8'h55);
    chk("movb_gf", gf_q, 1);
    issue(4'b0001, 8'h11);
    issue(4'b0100, 8'd0);
    chk("mova_au_a", au_a, 8'h55);
    tick();
    chk("mova_ra", ra_q, 8'h55);
    chk("mova_gf", gf_q, 1);

    // OUT with backpressure; an offered LDB must be ignored meanwhile
    issue(4'b0001, 8'h7F);
    issue(4'b1101, 8'd0);
    chk("out_ac", ac, 4'b1101);
    chk("out_au_a", au_a, 8'h7F);
    chk("out_exec_valid", out_valid, 0);
    in_valid = 1'b1; in_op = 4'b0010; in_data = 8'h99;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("outw_valid", out_valid, 1);
      chk("outw_data", out_data, 8'h7F);
      chk("outw_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_done_valid", out_valid, 0);
    chk("out_done_in_ready", in_ready, 1);
    chk("out_ignored_ldb", rb_q, 8'h55);

    // out_ready during EXEC has no effect
    issue(4'b0001, 8'h22);
    issue(4'b1101, 8'd0);
    out_ready = 1'b1;
    tick();
    chk("outx_valid", out_valid, 1);
    chk("outx_data", out_data, 8'h22);
    tick();
    out_ready = 1'b0;
    chk("outx_done", out_valid, 0);

    // Unknown opcode pulse
    issue(4'b0001, 8'h7F);
    issue(4'b1111, 8'd0);
    chk("bad_pulse", bad_op, 1);
    chk("bad_ra", ra_q, 8'h7F);
    chk("bad_rb", rb_q, 8'h55);
    chk("bad_gf", gf_q, 1);
    chk("bad_in_ready", in_ready, 1);
    tick();
    chk("bad_clear", bad_op, 0);

    // Back-to-back loads on consecutive edges
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0001; in_data = 8'h12;
    @(posedge clk); #1;
    chk("b2b_in_ready", in_ready, 1);
    in_op = 4'b0010; in_data = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_ra", ra_q, 8'h12);
    chk("b2b_rb", rb_q, 8'h34);

    // Reset during EXEC abandons the ADD
    issue(4'b0001, 8'd5);
    issue(4'b0010, 8'd9);
    issue(4'b1000, 8'd0);
    rst = 1'b1;
    tick();
    chk("rexec_ra", ra_q, 0);
    chk("rexec_rb", rb_q, 0);
    chk("rexec_gf", gf_q, 0);
    chk("rexec_au_en", au_en, 0);
    chk("rexec_in_ready", in_ready, 0);
    rst = 1'b0; #1;
    chk("rexec_idle", in_ready, 1);

    // Reset during OUT_WAIT drops the output
    issue(4'b0001, 8'h44);
    issue(4'b1101, 8'd0);
    tick();
    chk("rout_valid_before", out_valid, 1);
    chk("rout_data_before", out_data, 8'h44);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rout_valid", out_valid, 0);
    chk("rout_data", out_data, 0);
    #1;
    chk("rout_idle", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/au_seq.md
# au_seq

Operand/sequencing stage directly upstream of the arithmetic unit. It accepts one instruction at a time over a valid/ready handshake and holds two signed operand registers, RA and RB. For ALU instructions it drives `au_en`, `ac`, `au_a` and `au_b` for exactly one cycle, then captures `au_t` and `au_gf` back into its registers. The OUT instruction presents RA on a downstream valid/ready output port.

## Interface
- `DATA_W`, default 8: operand/result width. Must match the arithmetic unit; only 8 is verified.

- `clk` in 1: the single clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: stage can accept; equals (state==IDLE && !rst).
- `in_op` in 4: opcode.
- `in_data` in DATA_W: immediate for LDA/LDB, otherwise ignored.
- `au_en` out 1: arithmetic-unit enable.
- `ac` out 4: arithmetic-unit opcode.
- `au_a` out DATA_W: arithmetic-unit operand a.
- `au_b` out DATA_W: arithmetic-unit operand b.
- `au_t` in DATA_W: arithmetic-unit result; sampled only in EXEC.
- `au_gf` in 1: arithmetic-unit greater flag; sampled only in EXEC.
- `out_valid` out 1: OUT result available.
- `out_ready` in 1: consumer accepts.
- `out_data` out DATA_W: OUT result, registered.
- `gf_q` out 1: registered greater flag.
- `ra_q`, `rb_q` out DATA_W: RA and RB, for debug.
- `bad_op` out 1: one-cycle pulse on an unknown opcode.

## Operation
- States: IDLE, EXEC, OUT_WAIT.
- An instruction is accepted on the rising edge where `in_valid && in_ready`.
- Single-cycle opcodes complete at the acceptance edge and stay in IDLE:
  - 0000 NOP: no effect.
  - 0001 LDA: RA <= `in_data`.
  - 0010 LDB: RB <= `in_data`.
  - Any other undefined code: `bad_op`=1 in the next cycle only; no other effect.
- ALU opcodes go IDLE -> EXEC, latching the opcode as `ac`:
  - 1000 ADD: `au_a`=RA, `au_b`=RB. RA <= `au_t` (RA+RB). `gf_q` <= 0.
  - 1001 SUB: `au_a`=RA, `au_b`=RB. RA <= `au_t` (RB-RA). `gf_q` <= `au_gf` (signed RB>RA).
  - 0100 MOVA: `au_a`=RB. RA <= `au_t`. `gf_q` unchanged.
  - 0101 MOVB: `au_a`=RA. RB <= `au_t`. `gf_q` unchanged.
  - 1101 OUT: `au_a`=RA. `out_data` <= `au_t`. Next state is OUT_WAIT instead of IDLE.
- EXEC lasts exactly one cycle: `au_en`=1, `ac`/`au_a`/`au_b` as listed, and `au_b`=0 where not listed.
- At the end-of-EXEC edge, the result and flag are written and the FSM goes to IDLE, or to OUT_WAIT for OUT.
- OUT_WAIT:
  - `out_valid`=1, `out_data` stable.
  - On the edge with `out_ready`=1, the FSM goes to IDLE and `out_valid`=0.
- Outside EXEC: `au_en`=0, `ac`=0000, `au_a`=`au_b`=0. `au_t` is not sampled, since it is high-Z while the unit is disabled.
- Arithmetic is DATA_W-bit two's complement with wrap-around; there is no overflow flag.
- Reset values (at the edge with `rst`=1):
  - State=IDLE; RA=RB=0; `gf_q`=0; `out_data`=0.
  - `out_valid`=0, `bad_op`=0, `au_en`=0, `ac`=0.
  - `in_ready`=0 while `rst` is high.
- Reset in EXEC or OUT_WAIT abandons the instruction: no RA/RB/`gf_q` write, and a pending OUT is dropped.

## Timing
- LDA/LDB/NOP: 1 cycle. `in_ready` stays high, so back-to-back acceptance is allowed.
- ADD/SUB/MOVA/MOVB: 2 cycles (accept + EXEC). `in_ready`=0 during EXEC. The updated RA/RB are visible on `ra_q`/`rb_q` in the cycle after EXEC.
- OUT: `out_valid` rises in the cycle after EXEC, so the minimum is 3 cycles when `out_ready` is held high. `in_ready`=0 until the out handshake edge.
- `out_ready` asserted during EXEC has no effect; only OUT_WAIT consumes it.
- `in_valid` while `in_ready`=0 is ignored; the upstream source must hold the instruction.

## Test plan
- Reset, then LDA 100, LDB 100, ADD -> EXEC cycle shows `au_en`=1 and `ac`=1000. Next cycle `ra_q`=0xC8 (-56, wrapped) and `gf_q`=0.
- LDA 3, LDB 10, SUB -> `ra_q`=7 and `gf_q`=1. Then LDA 10, LDB 3, SUB -> `ra_q`=-7 (0xF9) and `gf_q`=0.
- LDA 0x55, LDB 0x22, MOVB -> `rb_q`=0x55. Then LDA 0x11, MOVA -> `ra_q`=0x55. `gf_q` is unchanged throughout.
- LDA 0x7F, OUT with `out_ready`=0 for 4 cycles -> `out_valid`=1 and `out_data`=0x7F held stable, `in_ready`=0. Raise `out_ready` -> `out_valid`=0 and `in_ready`=1 on the next cycle.
- Opcode 1111 -> `bad_op` high for exactly 1 cycle, RA/RB/`gf_q` unchanged. Back-to-back LDA, LDB accepted on consecutive edges.
- LDA 5, LDB 9, ADD, with `rst` asserted during EXEC -> next cycle RA=RB=0, `gf_q`=0, state IDLE, `au_en`=0. Also OUT with `rst` asserted during OUT_WAIT -> `out_valid`=0.
